// File: rtl/execute_stage_if.sv
// Execute-stage bundle: E register fields in, forwarding, CC and M register out.
interface execute_stage_if #(
  parameter int W = 64
);
  logic [1:0]   E_stat;
  logic [3:0]   E_icode;
  logic [3:0]   E_ifun;
  logic [W-1:0] E_valA;
  logic [W-1:0] E_valB;
  logic [W-1:0] E_valC;
  logic [3:0]   E_dstE;
  logic [3:0]   E_dstM;
  logic         m_exc;
  logic         W_exc;
  logic         M_stall;
  logic         M_bubble;
  logic [W-1:0] e_valE;
  logic [3:0]   e_dstE;
  logic         e_Cnd;
  logic [2:0]   cc;
  logic [1:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_Cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;

  modport master (
    output E_stat, E_icode, E_ifun,
    output E_valA, E_valB, E_valC,
    output E_dstE, E_dstM,
    output m_exc, W_exc, M_stall, M_bubble,
    input  e_valE, e_dstE, e_Cnd, cc,
    input  M_stat, M_icode, M_Cnd,
    input  M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  E_stat, E_icode, E_ifun,
    input  E_valA, E_valB, E_valC,
    input  E_dstE, E_dstM,
    input  m_exc, W_exc, M_stall, M_bubble,
    output e_valE, e_dstE, e_Cnd, cc,
    output M_stat, M_icode, M_Cnd,
    output M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand select, ripple-carry ALU, condition codes,
// branch/cmov condition and the M pipeline register.
module execute_stage (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave e
);
  localparam int W = 64;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] INOP  = 4'h1;

  logic [W-1:0] alua;
  logic [W-1:0] alub;
  logic [W-1:0] addb;
  logic [W-1:0] sum;
  logic [W-1:0] res;
  logic [3:0]   fn;
  logic         sub;
  logic         cy;
  logic         zf_n;
  logic         sf_n;
  logic         of_n;
  logic         set_cc;
  logic         zf;
  logic         sf;
  logic         of;
  logic         cnd;
  logic [2:0]   cc_q;

  always_comb begin
    alua = '0;
    unique case (1'b1)
      e.E_icode == 4'h2,
      e.E_icode == 4'h6: alua = e.E_valA;
      e.E_icode == 4'h3,
      e.E_icode == 4'h4,
      e.E_icode == 4'h5: alua = e.E_valC;
      e.E_icode == 4'h8,
      e.E_icode == 4'hA: alua = -64'sd8;
      e.E_icode == 4'h9,
      e.E_icode == 4'hB: alua = 64'd8;
      default:           alua = '0;
    endcase
  end

  always_comb begin
    alub = '0;
    unique case (1'b1)
      e.E_icode == 4'h4,
      e.E_icode == 4'h5,
      e.E_icode == 4'h6,
      e.E_icode == 4'h8,
      e.E_icode == 4'h9,
      e.E_icode == 4'hA,
      e.E_icode == 4'hB: alub = e.E_valB;
      default:           alub = '0;
    endcase
  end

  assign fn   = (e.E_icode == 4'h6) ? e.E_ifun : 4'h0;
  assign sub  = (fn == 4'h1);
  assign addb = sub ? ~alua : alua;

  // subtraction reuses the adder as B + ~A + 1
  always_comb begin
    sum = '0;
    cy  = sub;
    for (int i = 0; i < W; i++) begin
      sum[i] = alub[i] ^ addb[i] ^ cy;
      cy     = (alub[i] & addb[i]) | (cy & (alub[i] ^ addb[i]));
    end
  end

  always_comb begin
    res = '0;
    unique case (fn)
      4'h0, 4'h1: res = sum;
      4'h2:       res = alub & alua;
      4'h3:       res = alub ^ alua;
      default:    res = '0;
    endcase
  end

  assign zf_n = (res == '0);
  assign sf_n = res[W-1];

  always_comb begin
    of_n = 1'b0;
    unique case (fn)
      4'h0: of_n = (alua[W-1] == alub[W-1]) &&
                   (res[W-1] != alua[W-1]);
      4'h1: of_n = (alua[W-1] != alub[W-1]) &&
                   (res[W-1] != alub[W-1]);
      default: of_n = 1'b0;
    endcase
  end

  assign set_cc = (e.E_icode == 4'h6) && (e.E_ifun <= 4'h3) &&
                  !e.m_exc && !e.W_exc && (e.E_stat == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cc_q <= 3'b100;
    else if (set_cc) cc_q <= {zf_n, sf_n, of_n};
  end

  assign {zf, sf, of} = cc_q;
  assign e.cc = cc_q;

  // conditions see the committed cc, not this cycle's flags
  always_comb begin
    cnd = 1'b0;
    unique case (e.E_ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (sf ^ of) | zf;
      4'h2:    cnd = sf ^ of;
      4'h3:    cnd = zf;
      4'h4:    cnd = !zf;
      4'h5:    cnd = !(sf ^ of);
      4'h6:    cnd = !(sf ^ of) & !zf;
      default: cnd = 1'b0;
    endcase
  end

  assign e.e_Cnd  = cnd;
  assign e.e_valE = res;
  assign e.e_dstE = (e.E_icode == 4'h2 && !cnd) ? RNONE : e.E_dstE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e.M_stat  <= 2'd0;
      e.M_icode <= INOP;
      e.M_Cnd   <= 1'b0;
      e.M_valE  <= '0;
      e.M_valA  <= '0;
      e.M_dstE  <= RNONE;
      e.M_dstM  <= RNONE;
    end else if (e.M_bubble) begin
      e.M_stat  <= 2'd0;
      e.M_icode <= INOP;
      e.M_Cnd   <= 1'b0;
      e.M_valE  <= '0;
      e.M_valA  <= '0;
      e.M_dstE  <= RNONE;
      e.M_dstM  <= RNONE;
    end else if (!e.M_stall) begin
      e.M_stat  <= e.E_stat;
      e.M_icode <= e.E_icode;
      e.M_Cnd   <= cnd;
      e.M_valE  <= res;
      e.M_valA  <= e.E_valA;
      e.M_dstE  <= e.e_dstE;
      e.M_dstM  <= e.E_dstM;
    end
  end
endmodule
